wb_ram_slave: RTL

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

---
 rtl/wb_ram_slave.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 slave wrapping a 2^ADDR_BITS x 32-bit RAM.
// Supports classic single cycles and incrementing bursts with linear or
// wrap-4/8/16 address sequencing. Read data is prefetched one cycle ahead so
// a burst with stb held high delivers one beat per clock.
//
// Ports:
//   wb_clk     in   bus clock, all state changes on its rising edge
//   wb_rst     in   asynchronous active-high reset
//   wb_cyc_i   in   bus cycle
//   wb_stb_i   in   strobe
//   wb_addr_i  in   word address [31:2], only [ADDR_BITS+1:2] decoded
//   wb_cti_i   in   cycle type: 000 classic, 010 incr burst, 111 end of burst
//   wb_bte_i   in   burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
//   wb_sel_i   in   byte enables
//   wb_we_i    in   write enable (sampled at start of access only)
//   wb_data_i  in   write data
//   wb_data_o  out  read data, zero whenever ack is low
//   wb_ack_o   out  transfer acknowledge
//
// state | meaning
// IDLE  | waiting for cyc & stb; latches address, bte and we on request
// ACK   | single classic beat, ack for one cycle then back to IDLE
// BURST | incrementing burst, ack follows stb while cyc is held

module wb_ram_slave #(
  parameter int ADDR_BITS = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [31:2] wb_addr_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [2:0] CTI_INC = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ctr_q, ctr_d;
  logic [1:0]             bte_q, bte_d;
  logic                   we_q, we_d;
  logic [31:0]            rd_q;
  logic                   wr_en;

  // Upper address bits alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^wb_addr_i[31:ADDR_BITS+2];

  // Wrap modes only count within the low 2/3/4 bits; the rest stay put.
  function automatic logic [ADDR_BITS-1:0] advance(
    input logic [ADDR_BITS-1:0] a,
    input logic [1:0]           bte
  );
    logic [ADDR_BITS-1:0] mask;
    logic [ADDR_BITS-1:0] inc;
    case (bte)
      2'b01:   mask = ADDR_BITS'(4'h3);
      2'b10:   mask = ADDR_BITS'(4'h7);
      2'b11:   mask = ADDR_BITS'(4'hF);
      default: mask = '1;
    endcase
    inc = a + ADDR_BITS'(1);
    return (a & ~mask) | (inc & mask);
  endfunction

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bte_q   <= 2'b00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bte_q   <= bte_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    bte_d    = bte_q;
    we_d     = we_q;
    wb_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          ctr_d   = wb_addr_i[ADDR_BITS+1:2];
          bte_d   = wb_bte_i;
          we_d    = wb_we_i;
          state_d = (wb_cti_i == CTI_INC) ? BURST : ACK;
        end
      end
      ACK: begin
        wb_ack_o = wb_cyc_i;
        state_d  = IDLE;
      end
      BURST: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          wb_ack_o = wb_stb_i;
          if (wb_stb_i) begin
            ctr_d = advance(ctr_q, bte_q);
            // Any code other than incrementing ends the burst; 111 is the
            // normal terminator, unknown codes behave like classic.
            if (wb_cti_i != CTI_INC) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en     = wb_ack_o & we_q;
  assign wb_data_o = wb_ack_o ? rd_q : 32'h0;

  // rd_q is loaded from the address the counter will hold next cycle, so the
  // word for each beat is ready when that beat is acked.
  if (INIT_ZERO != 0) begin : g_mem_zero
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    always_ff @(posedge wb_clk) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en && wb_sel_i[b]) mem[ctr_q][8*b +: 8] <= wb_data_i[8*b +: 8];
      end
      rd_q <= mem[ctr_d];
    end
  end else begin : g_mem_plain
    logic [31:0] mem [DEPTH];
    always_ff @(posedge wb_clk) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en && wb_sel_i[b]) mem[ctr_q][8*b +: 8] <= wb_data_i[8*b +: 8];
      end
      rd_q <= mem[ctr_d];
    end
  end

endmodule
